mem_rd_arbiter: RTL

Arbiter and sequencer for the shared image/filter memory: one combinational read port (`rd_adr` → `rd_data`) plus one bulk image-write strobe (`write_en`). Two read requesters share the read port under round-robin arbitration: requester 0 is the filter fetch and requester 1 is the image-window fetch. The image loader requests the bulk write, and writes take priority over reads. The block sits between the convolution controllers and the memory, and owns every memory control signal.

---
 rtl/mem_rd_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_rd_arbiter.sv
// Round-robin read arbiter plus bulk-write sequencer for the shared image/filter memory.
// Read: gnt 1 cycle after req is sampled, rsp 1 cycle later; a write pending in ARB pre-empts reads.
module mem_rd_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MEM_SIZE = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              wr_req,
   output logic              wr_done,
   output logic [ADDR_W-1:0] mem_rd_adr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_write_en,
   output logic              busy
);

   typedef enum logic [1:0] {ARB, READ, WRITE, WDONE} state_t;

   localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_SIZE);

   state_t state;
   state_t state_nxt;
   logic   last;
   logic   win;
   logic   win_nxt;
   logic   rd_take;
   logic   rd_oor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB;
      end else begin
         state <= state_nxt;
      end
   end

   // On a tie the requester that did not win last time is served.
   always_comb begin
      state_nxt = state;
      rd_take   = 1'b0;
      win_nxt   = win;
      case (state)
         ARB: begin
            if (wr_req) begin
               state_nxt = WRITE;
            end else if (req != 2'b00) begin
               rd_take   = 1'b1;
               state_nxt = READ;
               win_nxt   = (req == 2'b11) ? ~last : req[1];
            end
         end
         READ:    state_nxt = ARB;
         WRITE:   state_nxt = WDONE;
         WDONE:   state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   assign rd_oor       = ({1'b0, mem_rd_adr} >= MEM_LIM);
   assign mem_write_en = (state == WRITE);
   assign wr_done      = (state == WDONE);
   assign busy         = (state != ARB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt        <= 2'b00;
         rsp_valid  <= 2'b00;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         mem_rd_adr <= '0;
         last       <= 1'b1;
         win        <= 1'b0;
      end else begin
         gnt       <= 2'b00;
         rsp_valid <= 2'b00;
         if (rd_take) begin
            mem_rd_adr <= win_nxt ? addr1 : addr0;
            gnt        <= win_nxt ? 2'b10 : 2'b01;
            last       <= win_nxt;
            win        <= win_nxt;
         end
         // Out-of-range reads return zero rather than whatever the memory decodes.
         if (state == READ) begin
            rsp_valid <= win ? 2'b10 : 2'b01;
            rsp_data  <= rd_oor ? '0 : mem_rd_data;
            rsp_err   <= rd_oor;
         end
      end
   end

endmodule
